ws2812_grid_driver: RTL and testbench
=====================================

# ws2812_grid_driver

Streams a 64-cell life grid to an 8x8 WS2812 LED matrix as a single-wire serial waveform. Sits downstream of the grid generator: it snapshots the 64-bit grid on `start` and drives `dout` through 1536 bit-cells and a latch gap. Its `frame_done` pulse is the generator's update tick, so a grid never changes mid-frame.

## Interface
- `T_BIT`, 15: clock cycles per WS2812 bit cell (1.25 us at 12 MHz).
- `T0H`, 5: high cycles for a 0 bit.
- `T1H`, 10: high cycles for a 1 bit.
- `T_LATCH`, 720: low cycles after the last bit (60 us at 12 MHz).
- `ON_COLOR`, 24'h10_00_00: GRB word sent for a live cell.
- `OFF_COLOR`, 24'h00_00_00: GRB word sent for a dead cell.
- Legal parameter range: 0 < `T0H` < `T1H` < `T_BIT`; `T_LATCH` >= 1.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: frame request; sampled only in IDLE.
- `grid_in` in 64: grid to display; bit i = LED i; captured on the accepted `start`.
- `busy` out 1: high in SEND and LATCH.
- `frame_done` out 1: one-cycle pulse at end of frame.
- `dout` out 1: registered WS2812 data line.

## Operation
- **States:**
  - IDLE: `dout`=0, `busy`=0.
  - SEND: pixel index 0..63, bit index 23..0, cycle counter 0..`T_BIT`-1.
  - LATCH: cycle counter 0..`T_LATCH`-1.
- **IDLE -> SEND** when `start`=1. `grid_in` is copied to a 64-bit snapshot, and pixel 0, bit 23 and cycle 0 are loaded. `start` in SEND or LATCH is ignored.
- **Pixel and bit order:**
  - Pixels go out in order 0 to 63.
  - Each pixel sends its 24-bit color MSB first.
  - The color is `ON_COLOR` if snapshot[i] = 1, else `OFF_COLOR`.
- **Bit cell:**
  - `dout`=1 for cycles 0..Th-1 of the cell, 0 for cycles Th..`T_BIT`-1.
  - Th = `T1H` for a 1 bit, `T0H` for a 0 bit.
  - Cells are back to back with no gaps.
- **SEND -> LATCH** after cycle `T_BIT`-1 of pixel 63, bit 0. `dout`=0 throughout LATCH.
- **LATCH -> IDLE** after cycle `T_LATCH`-1. `frame_done`=1 for exactly the first IDLE cycle.
- **`start` in the `frame_done` cycle** is accepted, since the block is in IDLE. This gives back-to-back frames.
- **Snapshot isolation:** `grid_in` changes after acceptance have no effect on the current frame.
- **Reset:**
  - `rst`=1 forces IDLE at the next edge: `dout`=0, `busy`=0, `frame_done`=0, all counters cleared.
  - This applies mid-bit and mid-frame. A truncated frame is abandoned and no `frame_done` is produced.
  - `rst` has priority over a coincident `start`.
- **Counter widths:** pixel 6 bits, bit 5 bits, cycle $clog2(max(`T_BIT`,`T_LATCH`)) bits. No counter may wrap; each is reloaded at its terminal value.

## Timing
- Reset values: `dout`=0, `busy`=0, `frame_done`=0, state IDLE.
- `start` is sampled at edge k.
- `busy` and `dout` (first high cycle) both go to 1 from the cycle after edge k.
- SEND lasts 64 x 24 x `T_BIT` cycles, 23040 at defaults.
- LATCH lasts `T_LATCH` cycles.
- `frame_done` is high exactly 23040 + 720 = 23760 cycles after the first `dout`-high cycle, at defaults.
- `busy` falls in the same cycle `frame_done` rises.
- `frame_done` is never high for two consecutive cycles.

## Structure
- **Package `ws2812_pkg`:**
  - state enum {IDLE, SEND, LATCH};
  - default timing constants;
  - `PIXELS`=64 and `BITS_PER_PIXEL`=24.
- **Sub-module `ws2812_bit_cell`:**
  - Inputs: `clk`, `rst`, `load`, `bit_val`.
  - Outputs: `dout`, `cell_done`.
  - Owns the `T_BIT` cycle counter and the high-time compare.
- **Top:** owns the FSM, the snapshot, the pixel/bit indices, color selection and the latch counter.

## Test plan
- **Single frame:** `grid_in`=64'h0000_0000_0000_0001, one `start` pulse.
  - Pixel 0 decodes as 24'h10_00_00; pixels 1..63 decode as 24'h000000.
  - `frame_done` fires after 23760 cycles.
- **Bit timing:** all-ones grid. Every 1-bit high pulse is 10 cycles and every 0-bit high pulse is 5 cycles, with period 15 and 1536 rising edges in total.
- **Snapshot isolation:** accept `start` with 64'hAAAA_AAAA_AAAA_AAAA, then change `grid_in` to 0 at cycle 100. The decoded frame alternates on/off per pixel.
- **Ignored start, then back-to-back:**
  - Pulse `start` during SEND and during LATCH: no restart, and `frame_done` timing is unchanged.
  - Pulse `start` in the `frame_done` cycle: the next frame's first `dout` high occurs the following cycle.
- **Reset mid-frame:** assert `rst` during pixel 30.
  - `dout`=0 and `busy`=0 at the next edge; no `frame_done` for that frame.
  - A subsequent `start` produces a full, correct frame.
- **Reset versus start:** `rst` and `start` high in the same cycle leaves the block in IDLE with `busy`=0.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 grid driver.
package ws2812_pkg;
    typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

    localparam int T_BIT_DEF   = 15;
    localparam int T0H_DEF     = 5;
    localparam int T1H_DEF     = 10;
    localparam int T_LATCH_DEF = 720;

    localparam logic [23:0] ON_COLOR_DEF  = 24'h10_00_00;
    localparam logic [23:0] OFF_COLOR_DEF = 24'h00_00_00;

    localparam int PIXELS         = 64;
    localparam int BITS_PER_PIXEL = 24;
endpackage

// File: rtl/ws2812_bit_cell.sv
// One WS2812 bit cell: T_BIT cycles, high for T0H or T1H cycles from the start.
module ws2812_bit_cell
    import ws2812_pkg::*;
#(
    parameter int T_BIT = T_BIT_DEF,
    parameter int T0H   = T0H_DEF,
    parameter int T1H   = T1H_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic bit_val,
    output logic dout,
    output logic cell_done
);
    localparam int CW = $clog2(T_BIT);
    localparam logic [CW-1:0] LAST = CW'(T_BIT - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] th;
    logic          active;

    assign cell_done = active && (cnt == LAST);

    // dout is precomputed for the cycle the counter is about to enter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            th     <= '0;
            active <= 1'b0;
            dout   <= 1'b0;
        end else if (load) begin
            cnt    <= '0;
            th     <= bit_val ? CW'(T1H) : CW'(T0H);
            active <= 1'b1;
            dout   <= 1'b1;
        end else if (cell_done) begin
            cnt    <= '0;
            active <= 1'b0;
            dout   <= 1'b0;
        end else if (active) begin
            cnt  <= cnt + CW'(1);
            dout <= (cnt + CW'(1)) < th;
        end
    end
endmodule

// File: rtl/ws2812_grid_driver.sv
// Streams a 64-cell grid snapshot to an 8x8 WS2812 matrix, then holds the latch gap.
module ws2812_grid_driver
    import ws2812_pkg::*;
#(
    parameter int          T_BIT     = T_BIT_DEF,
    parameter int          T0H       = T0H_DEF,
    parameter int          T1H       = T1H_DEF,
    parameter int          T_LATCH   = T_LATCH_DEF,
    parameter logic [23:0] ON_COLOR  = ON_COLOR_DEF,
    parameter logic [23:0] OFF_COLOR = OFF_COLOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] grid_in,
    output logic        busy,
    output logic        frame_done,
    output logic        dout
);
    localparam int CMAX = (T_BIT > T_LATCH) ? T_BIT : T_LATCH;
    localparam int LW   = $clog2(CMAX);
    localparam logic [LW-1:0] LATCH_LAST = LW'(T_LATCH - 1);
    localparam logic [5:0]    LAST_PIX   = 6'(PIXELS - 1);
    localparam logic [4:0]    TOP_BIT    = 5'(BITS_PER_PIXEL - 1);

    state_t        state;
    logic [63:0]   snap;
    logic [5:0]    pix;
    logic [5:0]    next_pix;
    logic [4:0]    bit_idx;
    logic [4:0]    next_bit;
    logic [LW-1:0] lcnt;
    logic          accept;
    logic          advance;
    logic          last_cell;
    logic          load;
    logic          bit_val;
    logic          cell_done;
    logic [23:0]   color;

    always_comb begin
        next_pix  = pix;
        next_bit  = bit_idx - 5'd1;
        color     = OFF_COLOR;
        bit_val   = 1'b0;
        if (bit_idx == 5'd0) begin
            next_pix = pix + 6'd1;
            next_bit = TOP_BIT;
        end
        last_cell = (pix == LAST_PIX) && (bit_idx == 5'd0);
        accept    = !rst && (state == IDLE) && start;
        advance   = (state == SEND) && cell_done && !last_cell;
        load      = accept || advance;
        // First bit comes straight from grid_in since the snapshot loads on the same edge
        if (accept) begin
            color   = grid_in[0] ? ON_COLOR : OFF_COLOR;
            bit_val = color[TOP_BIT];
        end else begin
            color   = snap[next_pix] ? ON_COLOR : OFF_COLOR;
            bit_val = color[next_bit];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            snap       <= '0;
            pix        <= '0;
            bit_idx    <= '0;
            lcnt       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SEND;
                        snap    <= grid_in;
                        pix     <= '0;
                        bit_idx <= TOP_BIT;
                        busy    <= 1'b1;
                    end
                end
                SEND: begin
                    if (cell_done) begin
                        if (last_cell) begin
                            state   <= LATCH;
                            lcnt    <= '0;
                            pix     <= '0;
                            bit_idx <= '0;
                        end else begin
                            pix     <= next_pix;
                            bit_idx <= next_bit;
                        end
                    end
                end
                LATCH: begin
                    if (lcnt == LATCH_LAST) begin
                        state      <= IDLE;
                        lcnt       <= '0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        lcnt <= lcnt + LW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ws2812_bit_cell #(
        .T_BIT (T_BIT),
        .T0H   (T0H),
        .T1H   (T1H)
    ) u_cell (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .bit_val   (bit_val),
        .dout      (dout),
        .cell_done (cell_done)
    );
endmodule

// File: tb/tb_ws2812_grid_driver.sv
// Directed/random bench: decodes dout pulses back into pixel colors and checks frame timing.
module tb_ws2812_grid_driver;
    localparam int TB_T_BIT   = 6;
    localparam int TB_T0H     = 2;
    localparam int TB_T1H     = 4;
    localparam int TB_T_LATCH = 37;
    localparam int NBITS      = 64 * 24;
    localparam int SEND_CYC   = NBITS * TB_T_BIT;
    localparam int FRAME      = SEND_CYC + TB_T_LATCH;
    localparam logic [23:0] EXP_ON  = 24'h10_00_00;
    localparam logic [23:0] EXP_OFF = 24'h00_00_00;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] grid_in;
    logic        busy;
    logic        frame_done;
    logic        dout;

    int n_cmp = 0;
    int n_bad = 0;

    ws2812_grid_driver #(
        .T_BIT   (TB_T_BIT),
        .T0H     (TB_T0H),
        .T1H     (TB_T1H),
        .T_LATCH (TB_T_LATCH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .grid_in    (grid_in),
        .busy       (busy),
        .frame_done (frame_done),
        .dout       (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts a frame from a negedge and follows it to frame_done (returns on that negedge)
    task automatic run_frame(input string tag, input logic [63:0] g,
                             input int chg_at, input logic [63:0] g2,
                             input bit poke);
        bit          dec[$];
        int          rises = 0;
        int          bad_w = 0;
        int          bad_p = 0;
        int          bad_b = 0;
        int          last_rise = -1;
        int          width = 0;
        int          fd_at = -1;
        int          pix_err = 0;
        logic        prev = 1'b0;
        logic [23:0] got;
        logic [23:0] p0 = '0;
        logic [23:0] expc;
        grid_in = g;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= FRAME + 4; c++) begin
            if (c > 0) @(negedge clk);
            if (c == chg_at) grid_in = g2;
            start = poke && (c == 4000 || c == SEND_CYC + 10);
            if (c == 0 && dout !== 1'b1) bad_b++;
            if (c == 0 && frame_done !== 1'b0) bad_b++;
            if (busy !== (c < FRAME)) bad_b++;
            if (c >= SEND_CYC && dout !== 1'b0) bad_b++;
            if (dout && !prev) begin
                rises++;
                if (last_rise >= 0 && c - last_rise != TB_T_BIT) bad_p++;
                last_rise = c;
                width = 0;
            end
            if (dout) width++;
            if (!dout && prev) begin
                if (width == TB_T1H) dec.push_back(1'b1);
                else if (width == TB_T0H) dec.push_back(1'b0);
                else bad_w++;
            end
            prev = dout;
            if (frame_done) begin
                fd_at = c;
                break;
            end
        end
        start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            got = '0;
            for (int k = 0; k < 24; k++)
                if (i * 24 + k < dec.size()) got = {got[22:0], dec[i * 24 + k]};
            expc = g[i] ? EXP_ON : EXP_OFF;
            if (got !== expc) pix_err++;
            if (i == 0) p0 = got;
        end
        chk({tag, ".frame_done_at"}, fd_at, FRAME);
        chk({tag, ".rises"}, rises, NBITS);
        chk({tag, ".decoded_bits"}, dec.size(), NBITS);
        chk({tag, ".bad_width"}, bad_w, 0);
        chk({tag, ".bad_period"}, bad_p, 0);
        chk({tag, ".busy_dout"}, bad_b, 0);
        chk({tag, ".pix0"}, p0, g[0] ? EXP_ON : EXP_OFF);
        chk({tag, ".pix_err"}, pix_err, 0);
    endtask

    initial begin
        int fd_cnt;
        int busy_cnt;
        logic [63:0] g;
        rst     = 1'b1;
        start   = 1'b0;
        grid_in = '0;
        repeat (3) @(negedge clk);
        chk("reset.dout", dout, 0);
        chk("reset.busy", busy, 0);
        chk("reset.frame_done", frame_done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame("single", 64'h0000_0000_0000_0001, -1, '0, 1'b0);
        @(negedge clk);
        chk("single.fd_pulse", frame_done, 0);
        chk("single.idle_busy", busy, 0);
        chk("single.idle_dout", dout, 0);
        repeat (3) @(negedge clk);

        run_frame("ones", '1, -1, '0, 1'b0);
        repeat (3) @(negedge clk);

        run_frame("snap", 64'hAAAA_AAAA_AAAA_AAAA, 100, '0, 1'b0);
        repeat (3) @(negedge clk);

        g = {$urandom, $urandom};
        run_frame("poke", g, -1, '0, 1'b1);
        g = {$urandom, $urandom};
        run_frame("b2b", g, -1, '0, 1'b0);
        @(negedge clk);
        chk("b2b.fd_pulse", frame_done, 0);
        repeat (3) @(negedge clk);

        grid_in = {$urandom, $urandom};
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30 * 24 * TB_T_BIT + 20) @(negedge clk);
        chk("rst_mid.busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid.dout", dout, 0);
        chk("rst_mid.busy", busy, 0);
        chk("rst_mid.frame_done", frame_done, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        chk("rst_vs_start.busy", busy, 0);
        chk("rst_vs_start.dout", dout, 0);
        fd_cnt   = 0;
        busy_cnt = 0;
        for (int c = 0; c < FRAME - 30 * 24 * TB_T_BIT + 50; c++) begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if (busy) busy_cnt++;
        end
        chk("rst_mid.no_frame_done", fd_cnt, 0);
        chk("rst_mid.stays_idle", busy_cnt, 0);

        g = {$urandom, $urandom};
        run_frame("after_rst", g, -1, '0, 1'b0);
        @(negedge clk);
        chk("after_rst.fd_pulse", frame_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
